// File: rtl/ahblite_bus_decoder_if.sv
// AHB-Lite bus bundle between the Cortex-M3 master port, the decoder and its slaves.
// A data phase completes on a rising HCLK edge where HREADY=1; while HREADY=0 the master
// holds its address phase and the decoder holds its registered select.
interface ahblite_bus_decoder_if #(
  parameter int NSLV = 4
) ();
  logic [31:0]        HADDR;
  logic [1:0]         HTRANS;
  logic [NSLV-1:0]    HSEL_S;
  logic               HSEL_DEF;
  logic [NSLV-1:0]    HREADYOUT_S;
  logic [NSLV*32-1:0] HRDATA_S;
  logic [NSLV-1:0]    HRESP_S;
  logic               HREADYOUT_D;
  logic [31:0]        HRDATA_D;
  logic               HRESP_D;
  logic               HREADY;
  logic [31:0]        HRDATA;
  logic               HRESP;

  // Decoder view.
  modport slave (
    input  HADDR, HTRANS, HREADYOUT_S, HRDATA_S, HRESP_S,
    input  HREADYOUT_D, HRDATA_D, HRESP_D,
    output HSEL_S, HSEL_DEF, HREADY, HRDATA, HRESP
  );

  // Environment view: master plus slaves.
  modport master (
    output HADDR, HTRANS, HREADYOUT_S, HRDATA_S, HRESP_S,
    output HREADYOUT_D, HRDATA_D, HRESP_D,
    input  HSEL_S, HSEL_DEF, HREADY, HRDATA, HRESP
  );
endinterface

// File: rtl/ahblite_bus_decoder.sv
// AHB-Lite address decoder and response mux with a wait-state timeout that aborts a
// hung transfer with a two-cycle ERROR response.
module ahblite_bus_decoder #(
  parameter int                 NSLV    = 4,
  parameter logic [NSLV*32-1:0] BASE    = {32'h4000_0000, 32'h2001_0000,
                                           32'h2000_0000, 32'h0000_0000},
  parameter logic [NSLV*32-1:0] MASK    = {32'hFFFF_0000, 32'hFFFF_0000,
                                           32'hFFFF_0000, 32'hFFFF_0000},
  parameter int                 TIMEOUT = 256
) (
  input  logic                        HCLK,
  input  logic                        HRESET,
  ahblite_bus_decoder_if.slave        bus,
  output logic [1:0]                  dbg_state,
  output logic [31:0]                 dbg_wcnt
);

  localparam int WCW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WCW-1:0] TMAX = WCW'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_DATA = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [NSLV:0]   sel_q, sel_d;
  logic [WCW-1:0]  wcnt_q, wcnt_d;

  logic [NSLV-1:0] hsel_s;
  logic            hit;
  logic            idle;
  logic            sel_rdy;
  logic            sel_resp;
  logic [31:0]     sel_rdata;
  logic            hready;
  logic            hresp;
  logic [31:0]     hrdata;
  logic            stalled;

  // Address decode: lowest matching slot wins, default slave otherwise.
  always_comb begin
    hsel_s = '0;
    hit    = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      if (!hit && ((bus.HADDR & MASK[32*i +: 32]) == BASE[32*i +: 32])) begin
        hsel_s[i] = 1'b1;
        hit       = 1'b1;
      end
    end
  end

  // AND-OR mux over the one-hot data-phase select; bit NSLV is the default slave.
  always_comb begin
    sel_rdy   = 1'b0;
    sel_resp  = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (sel_q[i]) begin
        sel_rdy   = sel_rdy   | bus.HREADYOUT_S[i];
        sel_resp  = sel_resp  | bus.HRESP_S[i];
        sel_rdata = sel_rdata | bus.HRDATA_S[32*i +: 32];
      end
    end
    if (sel_q[NSLV]) begin
      sel_rdy   = sel_rdy   | bus.HREADYOUT_D;
      sel_resp  = sel_resp  | bus.HRESP_D;
      sel_rdata = sel_rdata | bus.HRDATA_D;
    end
  end

  assign idle    = (sel_q == '0);
  assign stalled = !idle && !sel_rdy;

  always_comb begin
    state_d = state_q;
    hready  = 1'b1;
    hresp   = 1'b0;
    hrdata  = '0;
    case (state_q)
      ST_DATA: begin
        hready = idle | sel_rdy;
        hresp  = sel_resp;
        hrdata = sel_rdata;
        if ((TIMEOUT != 0) && stalled && (wcnt_q == TMAX)) state_d = ST_ERR1;
      end
      ST_ERR1: begin
        hready  = 1'b0;
        hresp   = 1'b1;
        state_d = ST_ERR2;
      end
      ST_ERR2: begin
        hready  = 1'b1;
        hresp   = 1'b1;
        state_d = ST_DATA;
      end
      default: state_d = ST_DATA;
    endcase
  end

  always_comb begin
    sel_d = sel_q;
    if (hready) sel_d = bus.HTRANS[1] ? {!hit, hsel_s} : '0;
  end

  // Wait counter saturates at TIMEOUT and only counts genuine slave stalls.
  always_comb begin
    wcnt_d = wcnt_q;
    if (hready)                                                 wcnt_d = '0;
    else if (state_q == ST_DATA && stalled && wcnt_q != TMAX)   wcnt_d = wcnt_q + 1'b1;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= ST_DATA;
      sel_q   <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign bus.HSEL_S   = hsel_s;
  assign bus.HSEL_DEF = !hit;
  assign bus.HREADY   = hready;
  assign bus.HRESP    = hresp;
  assign bus.HRDATA   = hrdata;
  assign dbg_state    = state_q;
  assign dbg_wcnt     = 32'(wcnt_q);

endmodule

// File: tb/tb_ahblite_bus_decoder.sv
// Directed bench for ahblite_bus_decoder: a per-cycle vector table for decode and
// muxing, then hand-written timeout and reset-in-ERR1 sequences.
module tb_ahblite_bus_decoder;

  logic        HCLK;
  logic        HRESET;
  logic [1:0]  dbg_state;
  logic [31:0] dbg_wcnt;
  int          tests;
  int          failures;

  ahblite_bus_decoder_if #(.NSLV(4)) bus ();

  ahblite_bus_decoder #(.NSLV(4), .TIMEOUT(4)) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .bus       (bus.slave),
    .dbg_state (dbg_state),
    .dbg_wcnt  (dbg_wcnt)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  typedef struct {
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic [3:0]  rdy_s;
    logic [3:0]  resp_s;
    logic        rdy_d;
    logic        resp_d;
    logic [3:0]  e_sel;
    logic        e_def;
    logic        e_rdy;
    logic        e_resp;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(logic [31:0] a, logic [1:0] t, logic [3:0] rs, logic [3:0] ps,
                              logic rd, logic pd, logic [3:0] es, logic ed, logic er,
                              logic ep, logic [31:0] edat);
    vec_t v;
    v.haddr = a;   v.htrans = t;  v.rdy_s = rs; v.resp_s = ps;
    v.rdy_d = rd;  v.resp_d = pd; v.e_sel = es; v.e_def = ed;
    v.e_rdy = er;  v.e_resp = ep; v.e_data = edat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_bus(input string name, input logic rdy, input logic resp, input logic [31:0] data);
    chk({name, "_hready"}, 32'(bus.HREADY), 32'(rdy));
    chk({name, "_hresp"},  32'(bus.HRESP),  32'(resp));
    chk({name, "_hrdata"}, bus.HRDATA, data);
  endtask

  initial begin
    tests    = 0;
    failures = 0;

    // Columns: addr, htrans, rdy_s, resp_s, rdy_d, resp_d | sel_s, def, hready, hresp, hrdata
    vecs[0]  = mk(32'h2000_0004, 2'b10, 4'hF, 4'h0, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b1, 1'b0, 32'h0);
    vecs[1]  = mk(32'h6000_0000, 2'b10, 4'hF, 4'h0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 32'hCAFE_F00D);
    vecs[2]  = mk(32'h0000_0010, 2'b00, 4'hF, 4'h0, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF);
    vecs[3]  = mk(32'h0000_0010, 2'b00, 4'hF, 4'h0, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    vecs[4]  = mk(32'h0000_0010, 2'b00, 4'hF, 4'h0, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF);
    vecs[5]  = mk(32'h4000_0020, 2'b10, 4'h0, 4'h1, 1'b1, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b0, 32'h0);
    vecs[6]  = mk(32'h2001_0000, 2'b00, 4'h7, 4'h0, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 32'hA000_0003);
    vecs[7]  = mk(32'h2001_0000, 2'b00, 4'hF, 4'h0, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b1, 1'b0, 32'hA000_0003);
    vecs[8]  = mk(32'hFFFF_0000, 2'b10, 4'hF, 4'h0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 32'h0);
    vecs[9]  = mk(32'h0000_0000, 2'b11, 4'hF, 4'h0, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);
    vecs[10] = mk(32'h4000_FFFF, 2'b01, 4'hF, 4'h0, 1'b1, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b0, 32'hA000_0000);
    vecs[11] = mk(32'h4001_0000, 2'b00, 4'hF, 4'h0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 32'h0);

    // Reset for two cycles with a slot2 address on the bus.
    HRESET          = 1'b1;
    bus.HADDR       = 32'h2001_1234;
    bus.HTRANS      = 2'b00;
    bus.HREADYOUT_S = 4'hF;
    bus.HRESP_S     = 4'h0;
    bus.HRDATA_S    = {32'hA000_0003, 32'hA000_0002, 32'hCAFE_F00D, 32'hA000_0000};
    bus.HREADYOUT_D = 1'b1;
    bus.HRESP_D     = 1'b0;
    bus.HRDATA_D    = 32'hDEAD_BEEF;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
    #1;
    chk_bus("reset", 1'b1, 1'b0, 32'h0);
    chk("reset_sel_s", 32'(bus.HSEL_S), 32'h4);
    chk("reset_sel_def", 32'(bus.HSEL_DEF), 32'h0);
    chk("reset_state", 32'(dbg_state), 32'd0);
    chk("reset_wcnt", dbg_wcnt, 32'd0);

    for (int i = 0; i < 12; i++) begin
      @(negedge HCLK);
      bus.HADDR       = vecs[i].haddr;
      bus.HTRANS      = vecs[i].htrans;
      bus.HREADYOUT_S = vecs[i].rdy_s;
      bus.HRESP_S     = vecs[i].resp_s;
      bus.HREADYOUT_D = vecs[i].rdy_d;
      bus.HRESP_D     = vecs[i].resp_d;
      #1;
      chk($sformatf("v%0d_sel_s", i), 32'(bus.HSEL_S), 32'(vecs[i].e_sel));
      chk($sformatf("v%0d_sel_def", i), 32'(bus.HSEL_DEF), 32'(vecs[i].e_def));
      chk_bus($sformatf("v%0d", i), vecs[i].e_rdy, vecs[i].e_resp, vecs[i].e_data);
    end

    // Timeout: slot2 stalls forever, TIMEOUT=4.
    @(negedge HCLK);
    bus.HADDR       = 32'h2001_0000;
    bus.HTRANS      = 2'b10;
    bus.HREADYOUT_S = 4'b1011;
    bus.HRESP_S     = 4'h0;
    bus.HREADYOUT_D = 1'b1;
    bus.HRESP_D     = 1'b0;
    #1;
    chk("to_addr_sel_s", 32'(bus.HSEL_S), 32'h4);
    chk_bus("to_addr", 1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 5; k++) begin
      @(negedge HCLK);
      bus.HTRANS = 2'b00;
      #1;
      chk($sformatf("to_wait%0d_hready", k), 32'(bus.HREADY), 32'h0);
      chk($sformatf("to_wait%0d_hresp", k), 32'(bus.HRESP), 32'h0);
      chk($sformatf("to_wait%0d_state", k), 32'(dbg_state), 32'd0);
      chk($sformatf("to_wait%0d_wcnt", k), dbg_wcnt, 32'(k));
    end
    @(negedge HCLK);
    #1;
    chk("to_err1_state", 32'(dbg_state), 32'd1);
    chk_bus("to_err1", 1'b0, 1'b1, 32'h0);
    bus.HREADYOUT_S = 4'hF;
    bus.HRESP_S     = 4'b0100;
    #1;
    chk_bus("to_err1_late_ready", 1'b0, 1'b1, 32'h0);
    @(negedge HCLK);
    #1;
    chk("to_err2_state", 32'(dbg_state), 32'd2);
    chk_bus("to_err2", 1'b1, 1'b1, 32'h0);
    @(negedge HCLK);
    bus.HREADYOUT_S = 4'b1011;
    bus.HRESP_S     = 4'h0;
    #1;
    chk("to_after_state", 32'(dbg_state), 32'd0);
    chk_bus("to_after", 1'b1, 1'b0, 32'h0);

    // Reset asserted while in ERR1.
    @(negedge HCLK);
    bus.HTRANS = 2'b10;
    for (int c = 0; c < 20; c++) begin
      @(negedge HCLK);
      bus.HTRANS = 2'b00;
      #1;
      if (dbg_state == 2'd1) break;
    end
    chk("rst_err1_reached", 32'(dbg_state), 32'd1);
    HRESET = 1'b1;
    @(negedge HCLK);
    HRESET = 1'b0;
    #1;
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk("rst_wcnt", dbg_wcnt, 32'd0);
    chk_bus("rst", 1'b1, 1'b0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
